// File: rtl/rblwe_pkg.sv
// rblwe_pkg: shared definitions for the RBLWE encryptor/decryptor pair.
//   Ring Z_q[x]/(x^N+1) with N = 512 coefficients of LOG_Q = 8 bits (q = 256).
//   Provides ring constants, coefficient/polynomial types, the controller state
//   encoding and the threshold-decode helper.
package rblwe_pkg;

    localparam int unsigned N          = 512;
    localparam int unsigned LOG_Q      = 8;
    localparam int unsigned NQ         = N * LOG_Q;
    localparam int unsigned CNT_W      = $clog2(N);
    localparam int unsigned Q          = 32'd1 << LOG_Q;
    localparam int unsigned Q_QUARTER  = Q / 32'd4;
    localparam int unsigned Q_3QUARTER = (32'd3 * Q) / 32'd4;

    typedef logic [LOG_Q-1:0] coef_t;
    typedef coef_t poly_t [N];

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MUL    = 2'd1,
        ADD    = 2'd2,
        DECODE = 2'd3
    } state_t;

    // A coefficient decodes to 1 when it lies in [q/4, 3q/4), i.e. closest to q/2.
    function automatic logic decode_bit(input coef_t c);
        return (32'(c) >= Q_QUARTER) && (32'(c) < Q_3QUARTER);
    endfunction

endpackage

// File: rtl/rblwe_nc_shift_acc.sv
// rblwe_nc_shift_acc: one combinational Horner step in Z_q[x]/(x^N+1).
//   o_acc_next = i_acc * x + (i_bit ? i_c1 : 0), every coefficient mod q.
//   Multiplying by x rotates coefficients up by one; the coefficient leaving
//   position N-1 re-enters at position 0 negated because x^N = -1.
// Ports:
//   i_acc      in  poly_t  current accumulator
//   i_c1       in  poly_t  multiplicand polynomial
//   i_bit      in  1       current secret bit (selects whether c1 is added)
//   o_acc_next out poly_t  accumulator after this step
module rblwe_nc_shift_acc
    import rblwe_pkg::*;
(
    input  poly_t i_acc,
    input  poly_t i_c1,
    input  logic  i_bit,
    output poly_t o_acc_next
);

    // Negacyclic shift plus conditional add; sums wrap naturally at LOG_Q bits.
    always_comb begin
        o_acc_next[0] = (coef_t'(0) - i_acc[N-1]) + (i_bit ? i_c1[0] : coef_t'(0));
        for (int i = 1; i < N; i++) begin
            o_acc_next[i] = i_acc[i-1] + (i_bit ? i_c1[i] : coef_t'(0));
        end
    end

endmodule

// File: rtl/rblwe_dec512.sv
// rblwe_dec512: RBLWE decryptor, d = c1*r2 + c2 in Z_q[x]/(x^N+1), then each
//   coefficient of d is threshold-decoded to one message bit.
//   The product is built serially by Horner's rule, one r2 bit per cycle from
//   the top bit down, so an operation takes N MUL cycles + ADD + DECODE.
// Ports:
//   clk    in  1   clock, all logic on posedge
//   rst    in  1   synchronous active-high reset (aborts any operation)
//   start  in  1   request, honoured only while idle
//   c1     in  NQ  ciphertext poly 1, coeff i = c1[i*LOG_Q +: LOG_Q]
//   c2     in  NQ  ciphertext poly 2, same packing
//   r2     in  N   binary secret, bit j = coefficient of x^j
//   busy   out 1   high while an operation is in progress
//   valid  out 1   one-cycle pulse when m is updated
//   m      out N   decoded message, held until the next result or reset
//   d_raw  out NQ  pre-threshold d (only with RBLWE_DEC_RAW_OUT_EN defined)
// Configuration macro: RBLWE_DEC_RAW_OUT_EN adds the d_raw output.
module rblwe_dec512
    import rblwe_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [NQ-1:0] c1,
    input  logic [NQ-1:0] c2,
    input  logic [N-1:0]  r2,
    output logic          busy,
    output logic          valid,
`ifdef RBLWE_DEC_RAW_OUT_EN
    output logic [NQ-1:0] d_raw,
`endif
    output logic [N-1:0]  m
);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    poly_t              r_c1;
    poly_t              r_c2;
    logic [N-1:0]       r_r2;
    poly_t              r_acc;
    logic               r_busy;
    logic               r_valid;
    logic [N-1:0]       r_m;
`ifdef RBLWE_DEC_RAW_OUT_EN
    logic [NQ-1:0]      r_d_raw;
`endif

    poly_t              w_acc_next;
    logic               w_bit;

    // Horner walks r2 from the highest power down: j = N-1-cnt = ~cnt.
    assign w_bit = r_r2[~r_cnt];

    rblwe_nc_shift_acc u_step (
        .i_acc      (r_acc),
        .i_c1       (r_c1),
        .i_bit      (w_bit),
        .o_acc_next (w_acc_next)
    );

    // Controller, operand latches, accumulator and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_m     <= '0;
            for (int i = 0; i < N; i++) begin
                r_acc[i] <= coef_t'(0);
            end
`ifdef RBLWE_DEC_RAW_OUT_EN
            r_d_raw <= '0;
`endif
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < N; i++) begin
                            r_c1[i]  <= c1[i*LOG_Q +: LOG_Q];
                            r_c2[i]  <= c2[i*LOG_Q +: LOG_Q];
                            r_acc[i] <= coef_t'(0);
                        end
                        r_r2    <= r2;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= MUL;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                MUL: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(N-1)) begin
                        r_state <= ADD;
                    end else begin
                        r_state <= MUL;
                    end
                end
                ADD: begin
                    for (int i = 0; i < N; i++) begin
                        r_acc[i] <= r_acc[i] + r_c2[i];
                    end
                    r_state <= DECODE;
                end
                DECODE: begin
                    for (int i = 0; i < N; i++) begin
                        r_m[i] <= decode_bit(r_acc[i]);
`ifdef RBLWE_DEC_RAW_OUT_EN
                        r_d_raw[i*LOG_Q +: LOG_Q] <= r_acc[i];
`endif
                    end
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign valid = r_valid;
    assign m     = r_m;
`ifdef RBLWE_DEC_RAW_OUT_EN
    assign d_raw = r_d_raw;
`endif

endmodule

// File: tb/tb_rblwe_dec512.sv
module tb_rblwe_dec512;
    import rblwe_pkg::*;

    logic          clk;
    logic          rst;
    logic          start;
    logic [NQ-1:0] c1;
    logic [NQ-1:0] c2;
    logic [N-1:0]  r2;
    logic          busy;
    logic          valid;
    logic [N-1:0]  m;
`ifdef RBLWE_DEC_RAW_OUT_EN
    logic [NQ-1:0] d_raw;
`endif

    int checks = 0;
    int errors = 0;

    rblwe_dec512 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .c1    (c1),
        .c2    (c2),
        .r2    (r2),
        .busy  (busy),
        .valid (valid),
`ifdef RBLWE_DEC_RAW_OUT_EN
        .d_raw (d_raw),
`endif
        .m     (m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges (continuing from lat0) until valid, with a bounded budget.
    task automatic wait_valid(input int lat0, input int bc0, output int lat, output int bc);
        lat = lat0;
        bc  = bc0;
        while (valid !== 1'b1 && lat < 700) begin
            tick();
            lat++;
            if (busy === 1'b1) bc++;
        end
    endtask

    // Start an operation from idle (or on the valid cycle), scramble the inputs
    // after the latch edge, and wait for the result.
    task automatic do_op(input logic [NQ-1:0] a, input logic [NQ-1:0] b,
                         input logic [N-1:0] s, output int lat, output int bc);
        c1 = a; c2 = b; r2 = s; start = 1'b1;
        tick();
        start = 1'b0;
        c1 = {128{$urandom()}};
        c2 = {128{$urandom()}};
        r2 = {16{$urandom()}};
        wait_valid(0, (busy === 1'b1) ? 1 : 0, lat, bc);
    endtask

    logic [NQ-1:0] va, vb;
    logic [N-1:0]  vs, exp_m;
    int lat, bc;

    initial begin
        rst = 1'b1; start = 1'b0; c1 = '0; c2 = '0; r2 = '0;
        tick(); tick();
        chk_int("reset_busy", int'(busy), 0);
        chk_int("reset_valid", int'(valid), 0);
        chk("reset_m", m, '0);
        rst = 1'b0;
        tick();

        // All c2 coefficients at q/2, c1 = 0: every bit decodes to 1.
        va = '0;
        for (int i = 0; i < N; i++) vb[i*8 +: 8] = 8'd128;
        vs = {16{$urandom()}};
        do_op(va, vb, vs, lat, bc);
        chk_int("half_latency", lat, 514);
        chk_int("half_busy_cycles", bc, 514);
        chk_int("half_valid", int'(valid), 1);
        chk_int("half_busy_done", int'(busy), 0);
        chk("half_m", m, '1);
        tick();
        chk_int("half_valid_pulse", int'(valid), 0);
        chk("half_m_held", m, '1);

        // All-zero ciphertext decodes to all zeros.
        do_op('0, '0, {16{$urandom()}}, lat, bc);
        chk_int("zero_latency", lat, 514);
        chk_int("zero_busy_cycles", bc, 514);
        chk("zero_m", m, '0);
        tick();
        chk_int("zero_valid_pulse", int'(valid), 0);

        // Threshold boundaries with r2 = 1 so d[0] = c1[0].
        va = '0; va[7:0] = 8'd64;
        do_op(va, '0, 512'd1, lat, bc);
        exp_m = '0; exp_m[0] = 1'b1;
        chk("bound_64", m, exp_m);
        va[7:0] = 8'd63;
        tick(); do_op(va, '0, 512'd1, lat, bc);
        chk("bound_63", m, '0);
        va[7:0] = 8'd192;
        tick(); do_op(va, '0, 512'd1, lat, bc);
        chk("bound_192", m, '0);
        va[7:0] = 8'd191;
        tick(); do_op(va, '0, 512'd1, lat, bc);
        chk("bound_191", m, exp_m);

        // Negacyclic wrap: c1[N-1]*x^N = -c1[N-1] at position 0.
        va = '0; va[(N-1)*8 +: 8] = 8'd200;
        tick(); do_op(va, '0, 512'd2, lat, bc);
        chk("wrap_200", m, '0);
        va[(N-1)*8 +: 8] = 8'd100;
        tick(); do_op(va, '0, 512'd2, lat, bc);
        chk("wrap_100", m, exp_m);

        // r2 = 1 + x^2; c1[0]=40, c1[N-1]=30; c2[0]=30, c2[N-1]=50.
        // d0=70 ->1, d1=-30=226 ->0, d2=40 ->0, d[N-1]=80 ->1.
        va = '0; vb = '0;
        va[7:0] = 8'd40; va[(N-1)*8 +: 8] = 8'd30;
        vb[7:0] = 8'd30; vb[(N-1)*8 +: 8] = 8'd50;
        vs = '0; vs[0] = 1'b1; vs[2] = 1'b1;
        exp_m = '0; exp_m[0] = 1'b1; exp_m[N-1] = 1'b1;
        tick(); do_op(va, vb, vs, lat, bc);
        chk("mix_m", m, exp_m);

        // r2 = 1; c2 addition with wrap: d3=100 ->1, d5=70 ->1, d7=300%256=44 ->0.
        va = '0; vb = '0;
        va[3*8 +: 8] = 8'd100;
        va[5*8 +: 8] = 8'd30;  vb[5*8 +: 8] = 8'd40;
        va[7*8 +: 8] = 8'd200; vb[7*8 +: 8] = 8'd100;
        exp_m = '0; exp_m[3] = 1'b1; exp_m[5] = 1'b1;
        tick(); do_op(va, vb, 512'd1, lat, bc);
        chk("add_wrap_m", m, exp_m);

        // Reset in the middle of MUL aborts, clears m, then a fresh op works.
        tick();
        for (int i = 0; i < N; i++) vb[i*8 +: 8] = 8'd128;
        c1 = '0; c2 = vb; r2 = '1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (100) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_int("abort_busy", int'(busy), 0);
        chk_int("abort_valid", int'(valid), 0);
        chk("abort_m", m, '0);
        tick();
        do_op('0, vb, '1, lat, bc);
        chk_int("after_abort_latency", lat, 514);
        chk("after_abort_m", m, '1);

        // start pulsed while busy is ignored: result and latency of first op stand.
        tick();
        c1 = '0; c2 = '0; r2 = '1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        c1 = '0; c2 = vb; start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(10, 0, lat, bc);
        chk_int("ignore_latency", lat, 514);
        chk("ignore_m", m, '0);

        // Back-to-back: start asserted on the valid cycle is accepted.
        do_op('0, vb, '0, lat, bc);
        chk_int("b2b_latency", lat, 514);
        chk("b2b_m", m, '1);
        tick();
        chk_int("b2b_valid_pulse", int'(valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
